fwrisc_regfile_ctrl: RTL
========================

// Module: fwrisc_regfile_ctrl
//
// PURPOSE
//   Write-port controller for the 64-entry register file (GPRs + CSR shadow).
//   - Post-reset: clear sequencer; writes CLEAR_VAL to every entry (the file itself has no reset).
//   - Run mode: arbitrates the single write port between core writeback and the debug/CSR requester.
//   - Enforces x0 (address 0) as read-only.
//
// PARAMETERS
//   NUM_REGS     64   entries to clear; must equal 2**ADDR_W
//   ADDR_W       6    write-address width
//   DATA_W       32   write-data width
//   CLEAR_VAL    0    value written to every entry during clear
//   STARVE_LIM   4    consecutive denied debug cycles before a forced debug grant (>=1)
//
// PORTS
//   clock        in   1       core clock
//   reset        in   1       async, active-high
//   core_wen     in   1       core writeback request
//   core_waddr   in   ADDR_W  core write address
//   core_wdata   in   DATA_W  core write data
//   core_wready  out  1       core write accepted this cycle; if 0, core holds its request
//   dbg_wreq     in   1       debug/CSR write request; held stable until acked
//   dbg_waddr    in   ADDR_W  debug write address
//   dbg_wdata    in   DATA_W  debug write data
//   dbg_wack     out  1       debug write accepted this cycle (1-cycle pulse per write)
//   rd_waddr     out  ADDR_W  to regfile write address
//   rd_wdata     out  DATA_W  to regfile write data
//   rd_wen       out  1       to regfile write enable
//   init_done    out  1       clear complete; regfile valid
//
// BEHAVIOUR
//   - Reset (async, any time, including mid-clear or mid-request):
//     - state=CLEAR, clr_cnt=0, starve_cnt=0, init_done=0.
//     - rd_wen, core_wready and dbg_wack are all 0 while reset is high.
//   - CLEAR state (entered on the first clock edge after reset falls):
//     - Each cycle: rd_wen=1, rd_waddr=clr_cnt, rd_wdata=CLEAR_VAL; clr_cnt increments.
//     - After the cycle writing NUM_REGS-1: state->RUN and init_done=1 (registered).
//     - Exactly NUM_REGS write cycles occur.
//     - core_wready=0 and dbg_wack=0 throughout; requests stay pending and are not lost.
//   - RUN state: arbitration is combinational within the cycle; rd_* are driven from the mux.
//     - Default priority goes to the core: core_wready=1 unless a forced debug grant is active.
//     - Debug is granted when dbg_wreq=1 and (core_wen=0 or forced):
//       dbg_wack=1 and rd_* come from dbg_*.
//     - Debug-only request: granted the same cycle.
//     - Simultaneous requests: core wins and starve_cnt increments.
//     - When starve_cnt==STARVE_LIM, that cycle is a forced grant:
//       - debug wins and core_wready=0;
//       - starve_cnt clears, and clears on any debug grant.
//     - starve_cnt also clears when dbg_wreq=0.
//     - Neither requester: rd_wen=0, dbg_wack=0.
//     - rd_waddr/rd_wdata hold the core values when idle (don't-care for the regfile).
//   - x0 protection (RUN only):
//     - A granted write with waddr==0 is acknowledged (core_wready/dbg_wack as normal) but rd_wen=0.
//     - The clear sequence does write address 0 (to CLEAR_VAL).
//   - Zero-latency path: a write accepted in cycle N is in the regfile at the edge ending cycle N.
//   - State encoding: 1 bit (CLEAR/RUN). RUN persists until the next reset.
//
// TESTING
//   1. Reset, then release -> exactly 64 consecutive rd_wen cycles with addr 0..63 and data 0;
//      init_done rises the cycle after addr 63; no rd_wen afterwards when idle.
//   2. Assert reset at clr_cnt=20 for 1 cycle -> outputs drop immediately;
//      clear restarts at addr 0; init_done only after a full 64-write pass.
//   3. RUN: core_wen addr 5, data 0xDEADBEEF -> same-cycle rd_wen=1, addr 5, data 0xDEADBEEF,
//      core_wready=1.
//   4. dbg_wreq held with core_wen continuously high, STARVE_LIM=4 -> 4 core writes, then 1 cycle
//      with core_wready=0, dbg_wack=1, rd_* = dbg values; then the core resumes.
//   5. Core writes addr 0 with data 0x1234, then debug writes addr 0 -> both acknowledged,
//      rd_wen=0 both cycles.
//   6. Core and debug requests held during CLEAR -> neither acked until init_done=1;
//      then the core is granted in the first RUN cycle and debug in the next.

Source files
------------

// File: rtl/fwrisc_regfile_ctrl_if.sv
// Purpose: register-file write bus: core writeback, debug/CSR requester and the regfile write port.
// Latency: pure wiring bundle, no storage.
// Backpressure: core holds core_wen until core_wready; debug holds dbg_wreq until the dbg_wack pulse.
//
// Signals:
//   core_wen/core_waddr/core_wdata -> core_wready   core writeback request and accept
//   dbg_wreq/dbg_waddr/dbg_wdata   -> dbg_wack      debug/CSR write request and accept pulse
//   rd_wen/rd_waddr/rd_wdata                        write port into the register file
// Modports: slave = controller side, master = requesters plus regfile observer.
interface fwrisc_regfile_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              core_wen;
  logic [ADDR_W-1:0] core_waddr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_wready;

  logic              dbg_wreq;
  logic [ADDR_W-1:0] dbg_waddr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_wack;

  logic [ADDR_W-1:0] rd_waddr;
  logic [DATA_W-1:0] rd_wdata;
  logic              rd_wen;

  modport slave (
    input  core_wen, core_waddr, core_wdata,
    output core_wready,
    input  dbg_wreq, dbg_waddr, dbg_wdata,
    output dbg_wack,
    output rd_waddr, rd_wdata, rd_wen
  );

  modport master (
    output core_wen, core_waddr, core_wdata,
    input  core_wready,
    output dbg_wreq, dbg_waddr, dbg_wdata,
    input  dbg_wack,
    input  rd_waddr, rd_wdata, rd_wen
  );
endinterface

// File: rtl/fwrisc_regfile_ctrl.sv
// Purpose: write-port controller for the register file: post-reset clear, core/debug arbitration, x0 protect.
// Latency: zero; an accepted write drives rd_* in the same cycle and lands at the closing clock edge.
// Backpressure: core_wready/dbg_wack low during clear; debug forced through after STARVE_LIM denied cycles.
//
// Ports:
//   clock, reset  core clock; asynchronous active-high reset
//   wr            fwrisc_regfile_ctrl_if.slave: core and debug requests in, regfile write port out
//   init_done     registered; high once every entry has been written with CLEAR_VAL
module fwrisc_regfile_ctrl #(
  parameter int              NUM_REGS   = 64,
  parameter int              ADDR_W     = 6,
  parameter int              DATA_W     = 32,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter int              STARVE_LIM = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  fwrisc_regfile_ctrl_if.slave wr,
  output logic                 init_done
);

  localparam int SC_W = $clog2(STARVE_LIM + 1);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [SC_W-1:0]   starve_cnt;

  logic              forced;
  logic              dbg_grant;
  logic              core_grant;
  logic              core_wready_c;
  logic              dbg_wack_c;
  logic              rd_wen_c;
  logic [ADDR_W-1:0] rd_waddr_c;
  logic [DATA_W-1:0] rd_wdata_c;

  always_comb begin
    forced        = 1'b0;
    dbg_grant     = 1'b0;
    core_grant    = 1'b0;
    core_wready_c = 1'b0;
    dbg_wack_c    = 1'b0;
    rd_wen_c      = 1'b0;
    rd_waddr_c    = wr.core_waddr;
    rd_wdata_c    = wr.core_wdata;
    // Reset gates the outputs directly so they drop the moment reset rises,
    // without waiting for the state register to settle.
    if (!reset) begin
      if (state == S_CLEAR) begin
        rd_wen_c   = 1'b1;
        rd_waddr_c = clr_cnt;
        rd_wdata_c = CLEAR_VAL;
      end else begin
        forced        = wr.dbg_wreq && (starve_cnt == SC_W'(STARVE_LIM));
        dbg_grant     = wr.dbg_wreq && (!wr.core_wen || forced);
        core_grant    = wr.core_wen && !forced;
        core_wready_c = !forced;
        dbg_wack_c    = dbg_grant;
        if (dbg_grant) begin
          rd_waddr_c = wr.dbg_waddr;
          rd_wdata_c = wr.dbg_wdata;
        end
        // x0 is hard-wired: the write is accepted but never reaches the file.
        rd_wen_c = (core_grant || dbg_grant) && (rd_waddr_c != '0);
      end
    end
  end

  assign wr.core_wready = core_wready_c;
  assign wr.dbg_wack    = dbg_wack_c;
  assign wr.rd_wen      = rd_wen_c;
  assign wr.rd_waddr    = rd_waddr_c;
  assign wr.rd_wdata    = rd_wdata_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_CLEAR;
      clr_cnt    <= '0;
      starve_cnt <= '0;
      init_done  <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == ADDR_W'(NUM_REGS - 1)) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN: begin
          // Count only cycles where debug is waiting and the core took the port.
          if (!wr.dbg_wreq || dbg_grant) begin
            starve_cnt <= '0;
          end else if (wr.core_wen) begin
            starve_cnt <= starve_cnt + SC_W'(1);
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule
